// File: rtl/router_pkg.sv
// Shared types and constants for mesh_gnrtr router nodes.
// Packet field layout, arbiter state encoding and sizing helper.
package router_pkg;

  localparam int PCKG_SZ = 40;

  // Packet fields, MSB first: next hop, destination row/column, mode, payload
  localparam int NXT_JUMP_W = 8;
  localparam int ID_ROW_W   = 4;
  localparam int ID_COLUM_W = 4;
  localparam int MODE_W     = 1;

  localparam int NXT_JUMP_LSB = PCKG_SZ - NXT_JUMP_W;
  localparam int ID_ROW_LSB   = NXT_JUMP_LSB - ID_ROW_W;
  localparam int ID_COLUM_LSB = ID_ROW_LSB - ID_COLUM_W;
  localparam int MODE_LSB     = ID_COLUM_LSB - MODE_W;
  localparam int PAYLOAD_LSB  = 0;
  localparam int PAYLOAD_W    = MODE_LSB;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FULL    = 2'd1,
    STALLED = 2'd2
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rtr_port_arbiter_rr_pick.sv
// Round-robin picker: first request above ptr, with wrap.
// Purely combinational, shared by the mesh arbiters.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic found;
    int   j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rtr_port_arbiter.sv
// Output-port arbiter: round-robin pop of input FIFOs into a
// one-entry output register, with grant stats and stall flag.
module rtr_port_arbiter
  import router_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int pckg_sz = 40,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_IN-1:0]           req_pndng,
  input  logic [N_IN*pckg_sz-1:0]   req_data,
  output logic [N_IN-1:0]           req_pop,
  input  logic [N_IN-1:0]           port_en,
  output logic [pckg_sz-1:0]        out_data,
  output logic                      out_pndng,
  input  logic                      out_popin,
  output logic [clog2(N_IN)-1:0]    grant_id,
  output logic                      stall_timeout,
  output logic [N_IN*CNT_W-1:0]     grant_cnt,
  input  logic                      cnt_clr
);

  localparam int IW = clog2(N_IN);
  localparam int WW = clog2(TIMEOUT) + 1;

  arb_state_e state_q, state_d;

  logic [N_IN-1:0]    elig;
  logic [N_IN-1:0]    pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [pckg_sz-1:0] pick_data;
  logic               slot_free;
  logic               pop;
  logic               grant;
  logic [WW-1:0]      wait_q;
  logic [CNT_W-1:0]   cnt_q [N_IN];

  assign elig      = req_pndng & port_en;
  assign out_pndng = (state_q != IDLE);
  assign slot_free = !out_pndng || out_popin;
  assign pop       = out_pndng && out_popin;

  rr_pick #(
    .N  (N_IN),
    .IW (IW)
  ) u_pick (
    .req (elig),
    .ptr (grant_id),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // No pop in the reset cycle: the packet would be lost
  assign grant   = slot_free && pick_any && !reset;
  assign req_pop = grant ? pick_gnt : '0;

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (pick_gnt[i]) pick_data = req_data[i*pckg_sz +: pckg_sz];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant) state_d = FULL;
      end
      FULL, STALLED: begin
        if (pop) begin
          state_d = grant ? FULL : IDLE;
        end else if (state_q == FULL
                     && wait_q == WW'(TIMEOUT - 1)) begin
          state_d = STALLED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      out_data      <= '0;
      grant_id      <= IW'(N_IN - 1);
      wait_q        <= '0;
      stall_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        out_data <= pick_data;
        grant_id <= pick_idx;
      end
      if (grant || pop) begin
        wait_q <= '0;
      end else if (out_pndng && wait_q != '1) begin
        wait_q <= wait_q + WW'(1);
      end
      if (state_q == FULL && state_d == STALLED) begin
        stall_timeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_IN; i++) begin
      if (reset || cnt_clr) begin
        cnt_q[i] <= '0;
      end else if (req_pop[i] && cnt_q[i] != '1) begin
        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_cnt
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_rtr_port_arbiter.sv
// Directed bench for rtr_port_arbiter.
// Hand-computed expectations for grant order, stats, stall, reset.
module tb_rtr_port_arbiter;

  localparam int N  = 4;
  localparam int PW = 40;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_pndng;
  logic [N*PW-1:0] req_data;
  logic [N-1:0]    req_pop;
  logic [N-1:0]    port_en;
  logic [PW-1:0]   out_data;
  logic            out_pndng;
  logic            out_popin;
  logic [1:0]      grant_id;
  logic            stall_timeout;
  logic [N*CW-1:0] grant_cnt;
  logic            cnt_clr;

  logic [PW-1:0]   pk [N];
  int              n_tests = 0;
  int              n_fail  = 0;

  rtr_port_arbiter #(
    .N_IN    (N),
    .pckg_sz (PW),
    .TIMEOUT (64),
    .CNT_W   (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_pndng     (req_pndng),
    .req_data      (req_data),
    .req_pop       (req_pop),
    .port_en       (port_en),
    .out_data      (out_data),
    .out_pndng     (out_pndng),
    .out_popin     (out_popin),
    .grant_id      (grant_id),
    .stall_timeout (stall_timeout),
    .grant_cnt     (grant_cnt),
    .cnt_clr       (cnt_clr)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) req_data[i*PW +: PW] = pk[i];
  end

  function automatic logic [PW-1:0] pkt(input int i);
    return 40'hC3_5A00_0000 | 40'(i * 40'h11_0101);
  endfunction

  function automatic logic [CW-1:0] cnt(input int i);
    return grant_cnt[i*CW +: CW];
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_w;
  int pops;

  initial begin
    for (int i = 0; i < N; i++) pk[i] = pkt(i);
    reset     = 1'b1;
    req_pndng = '0;
    port_en   = '1;
    out_popin = 1'b0;
    cnt_clr   = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;

    // reset state
    chk("rst_pndng", 64'(out_pndng), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd3);
    chk("rst_cnt", 64'(grant_cnt), 64'd0);
    chk("rst_stall", 64'(stall_timeout), 64'd0);
    chk("rst_pop", 64'(req_pop), 64'd0);

    // single requester, downstream always popping
    req_pndng = 4'b0100;
    out_popin = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("single_pop", 64'(req_pop), 64'b0100);
      step();
      chk("single_pndng", 64'(out_pndng), 64'd1);
      chk("single_gid", 64'(grant_id), 64'd2);
      chk("single_data", 64'(out_data), 64'(pkt(2)));
    end
    chk("single_cnt2", 64'(cnt(2)), 64'd5);
    req_pndng = '0;
    step();
    chk("single_drain", 64'(out_pndng), 64'd0);
    step();
    chk("popin_empty", 64'(out_pndng), 64'd0);

    // fairness from a fresh pointer
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_pndng = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      exp_w = c % 4;
      #1;
      chk("fair_pop", 64'(req_pop), 64'(1 << exp_w));
      step();
      chk("fair_gid", 64'(grant_id), 64'(exp_w));
      chk("fair_data", 64'(out_data), 64'(pkt(exp_w)));
    end
    for (int i = 0; i < N; i++) chk("fair_cnt", 64'(cnt(i)), 64'd2);

    // masked inputs 0 and 2
    reset = 1'b1;
    step();
    reset = 1'b0;
    port_en = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      exp_w = (c % 2 == 0) ? 1 : 3;
      #1;
      chk("mask_pop", 64'(req_pop), 64'(1 << exp_w));
      step();
      chk("mask_gid", 64'(grant_id), 64'(exp_w));
    end
    chk("mask_cnt0", 64'(cnt(0)), 64'd0);
    chk("mask_cnt1", 64'(cnt(1)), 64'd2);
    chk("mask_cnt2", 64'(cnt(2)), 64'd0);
    chk("mask_cnt3", 64'(cnt(3)), 64'd2);

    // backpressure and stall
    reset = 1'b1;
    step();
    reset = 1'b0;
    port_en   = 4'b1111;
    req_pndng = 4'b0001;
    out_popin = 1'b0;
    #1;
    chk("bp_first_pop", 64'(req_pop), 64'b0001);
    step();
    pk[0] = 40'h55_5555_5555;
    pops = 0;
    for (int c = 1; c <= 63; c++) begin
      #1;
      if (req_pop != '0) pops++;
      step();
    end
    chk("bp_no_pop", 64'(pops), 64'd0);
    chk("bp_stall63", 64'(stall_timeout), 64'd0);
    chk("bp_data", 64'(out_data), 64'(pkt(0)));
    step();
    chk("bp_stall64", 64'(stall_timeout), 64'd1);
    chk("bp_cnt0", 64'(cnt(0)), 64'd1);
    pk[0] = pkt(0);
    req_pndng = '0;
    out_popin = 1'b1;
    step();
    chk("bp_drain", 64'(out_pndng), 64'd0);
    chk("bp_sticky", 64'(stall_timeout), 64'd1);

    // reset mid-operation
    req_pndng = 4'b1100;
    out_popin = 1'b0;
    step();
    chk("mid_pndng", 64'(out_pndng), 64'd1);
    chk("mid_gid", 64'(grant_id), 64'd2);
    reset = 1'b1;
    out_popin = 1'b1;
    #1;
    chk("mid_rst_pop", 64'(req_pop), 64'd0);
    step();
    reset = 1'b0;
    #1;
    chk("mid_pndng0", 64'(out_pndng), 64'd0);
    chk("mid_cnt", 64'(grant_cnt), 64'd0);
    chk("mid_stall", 64'(stall_timeout), 64'd0);
    chk("mid_next_pop", 64'(req_pop), 64'b0100);
    step();
    chk("mid_next_gid", 64'(grant_id), 64'd2);

    // counter clear racing a grant
    req_pndng = 4'b0010;
    cnt_clr   = 1'b1;
    #1;
    chk("clr_pop", 64'(req_pop), 64'b0010);
    step();
    cnt_clr = 1'b0;
    chk("clr_cnt1", 64'(cnt(1)), 64'd0);
    chk("clr_cnt2", 64'(cnt(2)), 64'd0);
    chk("clr_data", 64'(out_data), 64'(pkt(1)));
    chk("clr_gid", 64'(grant_id), 64'd1);
    step();
    chk("clr_cnt1_inc", 64'(cnt(1)), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
